hs_txn_recorder: RTL and testbench
==================================

// Module: hs_txn_recorder
// PURPOSE
//  Synthesizable per-module transaction recorder that sits directly downstream of an HLS block's
//  ap_start/ap_ready/ap_done/ap_continue handshake.
//  It timestamps each transaction issue and completion, pairs them in order, and emits records over
//  a valid/ready stream. Records carry id, start time, latency and issue interval. They feed the CSV
//  status dump path or on-chip trace memory.
//  Emits one SUMMARY record when `finish` is seen.
// PARAMETERS
//  CNT_W     32  width of free-running cycle counter, timestamps, latency, II
//  ID_W      16  width of transaction id (wraps modulo 2^ID_W)
//  INFLIGHT  4   depth of issued-not-done queue (power of 2, >=2)
//  OUT_DEPTH 8   depth of output record FIFO (power of 2, >=2)
// PORTS
//  clock        in   1      single clock, all logic rising-edge
//  reset        in   1      synchronous, active-low (reset==0 resets)
//  finish       in   1      end of run; level, sampled each cycle
//  ap_start     in   1      observed module start
//  ap_ready     in   1      observed module input-accepted
//  ap_done      in   1      observed module completion
//  ap_continue  in   1      observed continue (tie 1 when module has none)
//  rec_valid    out  1      record available
//  rec_ready    in   1      consumer accepts record when rec_valid&rec_ready
//  rec          out  rec_t  {kind, id, start_ts, latency, ii} (hs_rec_pkg)
//  drop_cnt     out  16     records lost to full output FIFO, saturating
//  err_flags    out  2      sticky: [0] in-flight overflow, [1] orphan done
//  busy         out  1      in-flight queue non-empty or FSM not IDLE
// BEHAVIOUR
//  Reset: all outputs 0, cyc_cnt=0, id=0, FSM=IDLE, both FIFOs empty; reset mid-run discards all.
//  cyc_cnt increments every cycle after reset; wraps modulo 2^CNT_W. All subtractions are modulo 2^CNT_W.
//  Start FSM states: IDLE, WAIT_RDY, FINAL, FLUSHED.
//   IDLE: if ap_start, latch start_ts=cyc_cnt.
//    If ap_ready is also high that cycle, issue and stay IDLE. Otherwise go to WAIT_RDY.
//   WAIT_RDY: on ap_start&ap_ready, issue, then go to IDLE.
//   Issue pushes {start_ts, id} into the in-flight queue, then id++.
//   II = cyc_cnt - prev_issue_ts. II is 0 for the first issue after reset.
//   finish=1 in IDLE/WAIT_RDY: go to FINAL. No further issues are accepted.
//    Pending dones are still paired during FINAL.
//   FINAL: when the in-flight queue is empty and the output FIFO is not full, write a SUMMARY record
//    (id=issue count, start_ts=cyc_cnt, latency=drop_cnt zero-extended). Then go to FLUSHED.
//   FLUSHED: terminal until reset.
//  Done: ap_done&ap_continue pops the oldest in-flight entry and writes a TXN record with
//   latency = cyc_cnt - start_ts + 1 and ii from that issue.
//   Same-cycle issue and done with an empty queue uses a bypass: latency=1, no push/pop.
//   Same-cycle issue and done with a non-empty queue pushes and pops together; the level is unchanged.
//  Done with an empty queue and no bypass: set err_flags[1]. No record.
//  Issue with a full queue (and no same-cycle pop): set err_flags[0]. Entry is dropped, id still increments.
//  Output FIFO full at write time: record dropped, drop_cnt++ (saturating at 16'hFFFF).
//   A simultaneous pop frees the slot first, so write succeeds.
//  Latency: record visible on rec_valid one cycle after the done cycle (registered FIFO write).
//  rec/rec_valid are stable while rec_valid&!rec_ready.
// CONFIGURATION
//  HS_REC_II_EN defined: the II tracker (prev_issue_ts register, subtractor, ii in the queue) is built.
//  HS_REC_II_EN undefined: rec.ii is tied 0 and that logic is not synthesized; all else is identical.
// STRUCTURE
//  hs_rec_pkg holds: rec_kind_e {REC_TXN=2'd0, REC_SUMMARY=2'd1}, rec_t packed struct,
//   infl_t {start_ts, id, ii}, state_e enum, and CNT_W/ID_W defaults.
//  Sub-module hs_rec_fifo: synchronous FIFO with active-low sync reset, parameterized by type and depth,
//   exposing full/empty/level. It is instantiated twice: in-flight queue and output FIFO.
// TESTING
//  1. Single txn: start=ready at cycle 5, done at cycle 9, rec_ready=1
//     -> TXN id=0 start_ts=5 latency=5 ii=0, rec_valid at cycle 10.
//  2. Pipelined: issues at 10,12,14; dones at 20,21,22
//     -> ids 0,1,2; latencies 11,10,9; ii 0,2,2 (0 when HS_REC_II_EN undefined).
//  3. Start at 3, ready at 6, done at 6 with empty queue
//     -> bypass, start_ts=3, latency=4; no err flag.
//  4. rec_ready=0 with 9 completed txns, OUT_DEPTH=8
//     -> 8 records held, drop_cnt=1; first record stable until accepted.
//  5. 5 issues with no done, INFLIGHT=4 -> err_flags[0]=1, busy=1; then done with empty queue -> err_flags[1]=1.
//  6. finish with 2 in flight, then 2 dones -> 2 TXN records, then SUMMARY id=issue count;
//     ap_start after finish ignored; reset=0 mid-run clears all outputs next cycle.

Source files
------------

// File: rtl/hs_rec_pkg.sv
// hs_rec_pkg: shared types and widths for the HLS handshake transaction recorder.
// Holds record/queue-entry structs, record kinds and start FSM state encodings.
package hs_rec_pkg;

    // Timestamp/latency/II width and transaction id width. These are fixed here
    // because the record struct on the top-level port is built from them.
    localparam int CNT_W = 32;
    localparam int ID_W  = 16;

    typedef enum logic [1:0] {
        REC_TXN     = 2'd0,
        REC_SUMMARY = 2'd1
    } rec_kind_e;

    typedef struct packed {
        rec_kind_e        kind;
        logic [ID_W-1:0]  id;
        logic [CNT_W-1:0] start_ts;
        logic [CNT_W-1:0] latency;
        logic [CNT_W-1:0] ii;
    } rec_t;

    typedef struct packed {
        logic [CNT_W-1:0] start_ts;
        logic [ID_W-1:0]  id;
        logic [CNT_W-1:0] ii;
    } infl_t;

    typedef logic [1:0] state_e;

    localparam state_e S_IDLE     = 2'd0;
    localparam state_e S_WAIT_RDY = 2'd1;
    localparam state_e S_FINAL    = 2'd2;
    localparam state_e S_FLUSHED  = 2'd3;

endpackage

// File: rtl/hs_rec_fifo.sv
// hs_rec_fifo: synchronous show-ahead FIFO, type and depth parameterized.
// Ports: clock, reset (sync active-low), push/din, pop/dout, full, empty, level.
// A push while full is accepted only when a pop frees a slot in the same cycle;
// a pop while empty is ignored. dout shows the head entry combinationally.
module hs_rec_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  T                       din,
    input  logic                   pop,
    output T                       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/hs_txn_recorder.sv
// hs_txn_recorder: timestamps ap_start/ap_ready issues and ap_done completions,
// pairs them in order and streams TXN records, plus one SUMMARY after finish.
// Ports: clock, reset (sync active-low), finish, ap_start, ap_ready, ap_done,
//   ap_continue in; rec_valid/rec_ready/rec record stream; drop_cnt, err_flags
//   ([0] in-flight overflow, [1] orphan done), busy.
// Build option: define HS_REC_II_EN to build the issue-interval tracker;
// without it rec.ii is always 0.
module hs_txn_recorder
    import hs_rec_pkg::*;
#(
    parameter int INFLIGHT  = 4,
    parameter int OUT_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        finish,
    input  logic        ap_start,
    input  logic        ap_ready,
    input  logic        ap_done,
    input  logic        ap_continue,
    output logic        rec_valid,
    input  logic        rec_ready,
    output rec_t        rec,
    output logic [15:0] drop_cnt,
    output logic [1:0]  err_flags,
    output logic        busy
);

    state_e                 state;
    logic [CNT_W-1:0]       cyc_cnt;
    logic [CNT_W-1:0]       start_ts_q;
    logic [ID_W-1:0]        id_cnt;
    logic [CNT_W-1:0]       ii_now;
    logic [CNT_W-1:0]       issue_ts;

    logic                   issue;
    logic                   done;
    logic                   bypass;
    logic                   ovf;
    logic                   orphan;
    logic                   txn_wr;
    logic                   sum_wr;
    logic                   drop_ev;

    logic                   infl_push;
    logic                   infl_pop;
    logic                   infl_full;
    logic                   infl_empty;
    logic [$clog2(INFLIGHT):0]  infl_level;
    infl_t                  issue_ent;
    infl_t                  infl_head;
    infl_t                  done_ent;

    logic                   out_push;
    logic                   out_pop;
    logic                   out_full;
    logic                   out_empty;
    logic [$clog2(OUT_DEPTH):0] out_level;
    rec_t                   txn_rec;
    rec_t                   sum_rec;
    rec_t                   out_din;
    rec_t                   out_dout;

    // Issues are only accepted before finish; finish wins in the same cycle.
    assign issue = (state == S_IDLE || state == S_WAIT_RDY)
                   && !finish && ap_start && ap_ready;

    // From IDLE the start cycle is the issue cycle; from WAIT_RDY use the latch.
    assign issue_ts = (state == S_IDLE) ? cyc_cnt : start_ts_q;

`ifdef HS_REC_II_EN
    logic [CNT_W-1:0] prev_issue_ts;
    logic             have_prev;

    always_ff @(posedge clock) begin
        if (!reset) begin
            prev_issue_ts <= '0;
            have_prev     <= 1'b0;
        end else if (issue) begin
            prev_issue_ts <= cyc_cnt;
            have_prev     <= 1'b1;
        end
    end

    assign ii_now = have_prev ? (cyc_cnt - prev_issue_ts) : '0;
`else
    assign ii_now = '0;
`endif

    assign done   = ap_done && ap_continue;
    // Issue and done in one cycle with nothing queued: pair them directly.
    assign bypass = issue && done && infl_empty;

    assign infl_pop  = done && !infl_empty;
    assign infl_push = issue && !bypass;
    assign ovf       = infl_push && infl_full && !infl_pop;
    assign orphan    = done && infl_empty && !bypass;

    assign issue_ent = '{start_ts: issue_ts, id: id_cnt, ii: ii_now};
    assign done_ent  = bypass ? issue_ent : infl_head;

    assign txn_wr = done && (bypass || !infl_empty);
    assign txn_rec = '{
        kind:     REC_TXN,
        id:       done_ent.id,
        start_ts: done_ent.start_ts,
        latency:  cyc_cnt - done_ent.start_ts + CNT_W'(1),
        ii:       done_ent.ii
    };

    // Summary waits for in-flight pairing to finish, so it never collides
    // with a TXN write (a TXN write with an empty queue needs an issue).
    assign sum_wr = (state == S_FINAL) && infl_empty && !out_full;
    assign sum_rec = '{
        kind:     REC_SUMMARY,
        id:       id_cnt,
        start_ts: cyc_cnt,
        latency:  {{(CNT_W-16){1'b0}}, drop_cnt},
        ii:       '0
    };

    assign out_push = txn_wr || sum_wr;
    assign out_din  = sum_wr ? sum_rec : txn_rec;
    assign out_pop  = rec_ready && !out_empty;
    assign drop_ev  = out_push && out_full && !out_pop;

    assign rec_valid = (out_level != '0);
    assign rec       = rec_valid ? out_dout : '0;
    assign busy      = (infl_level != '0) || (state != S_IDLE);

    hs_rec_fifo #(
        .T     (infl_t),
        .DEPTH (INFLIGHT)
    ) u_infl (
        .clock (clock),
        .reset (reset),
        .push  (infl_push),
        .din   (issue_ent),
        .pop   (infl_pop),
        .dout  (infl_head),
        .full  (infl_full),
        .empty (infl_empty),
        .level (infl_level)
    );

    hs_rec_fifo #(
        .T     (rec_t),
        .DEPTH (OUT_DEPTH)
    ) u_out (
        .clock (clock),
        .reset (reset),
        .push  (out_push),
        .din   (out_din),
        .pop   (out_pop),
        .dout  (out_dout),
        .full  (out_full),
        .empty (out_empty),
        .level (out_level)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_IDLE;
            cyc_cnt    <= '0;
            start_ts_q <= '0;
            id_cnt     <= '0;
            drop_cnt   <= '0;
            err_flags  <= '0;
        end else begin
            cyc_cnt   <= cyc_cnt + 1'b1;
            err_flags <= err_flags | {orphan, ovf};
            if (issue) begin
                id_cnt <= id_cnt + 1'b1;
            end
            if (drop_ev && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (finish) begin
                        state <= S_FINAL;
                    end else if (ap_start) begin
                        start_ts_q <= cyc_cnt;
                        if (!ap_ready) begin
                            state <= S_WAIT_RDY;
                        end
                    end
                end
                S_WAIT_RDY: begin
                    if (finish) begin
                        state <= S_FINAL;
                    end else if (ap_start && ap_ready) begin
                        state <= S_IDLE;
                    end
                end
                S_FINAL: begin
                    if (sum_wr) begin
                        state <= S_FLUSHED;
                    end
                end
                default: state <= S_FLUSHED;
            endcase
        end
    end

endmodule

// File: tb/tb_hs_txn_recorder.sv
// tb_hs_txn_recorder: directed scenarios for hs_txn_recorder with a record
// scoreboard; honours HS_REC_II_EN for expected ii values.
module tb_hs_txn_recorder;
    import hs_rec_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        finish = 1'b0;
    logic        ap_start = 1'b0;
    logic        ap_ready = 1'b0;
    logic        ap_done = 1'b0;
    logic        ap_continue = 1'b1;
    logic        rec_ready = 1'b0;
    logic        rec_valid;
    rec_t        rec;
    logic [15:0] drop_cnt;
    logic [1:0]  err_flags;
    logic        busy;

    int   checks = 0;
    int   errors = 0;
    int   tcyc = 0;
    rec_t sb[$];
    rec_t mon_exp;
    rec_t first_rec;

    hs_txn_recorder #(
        .INFLIGHT  (4),
        .OUT_DEPTH (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .finish      (finish),
        .ap_start    (ap_start),
        .ap_ready    (ap_ready),
        .ap_done     (ap_done),
        .ap_continue (ap_continue),
        .rec_valid   (rec_valid),
        .rec_ready   (rec_ready),
        .rec         (rec),
        .drop_cnt    (drop_cnt),
        .err_flags   (err_flags),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    // Reference cycle count: 0 in the cycle after the last reset edge.
    always @(posedge clock) tcyc <= reset ? tcyc + 1 : 0;

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t mk(rec_kind_e k, int id, int st, int lat, int ii);
        rec_t r;
        r.kind     = k;
        r.id       = id[15:0];
        r.start_ts = st;
        r.latency  = lat;
        r.ii       = ii;
        return r;
    endfunction

    function automatic int iiv(int v);
`ifdef HS_REC_II_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    // Drive at negedge; the record accepted at the next posedge is the one
    // visible now with rec_ready as just driven.
    always @(negedge clock) begin
        #1;
        if (reset && rec_valid && rec_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_rec observed %0h expected none", rec);
            end
            if (sb.size() != 0) begin
                mon_exp = sb.pop_front();
                chk("rec", rec, mon_exp);
            end
        end
    end

    task automatic go(int n);
        int g;
        g = 0;
        @(negedge clock);
        while (tcyc < n && g < 500) begin
            @(negedge clock);
            g++;
        end
        if (tcyc != n) begin
            errors++;
            $error("FAIL sched observed %0d expected %0d", tcyc, n);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        finish = 1'b0;
        ap_start = 1'b0;
        ap_ready = 1'b0;
        ap_done = 1'b0;
        rec_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic hs(logic s, logic r, logic d);
        ap_start = s;
        ap_ready = r;
        ap_done  = d;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_valid", rec_valid, 0);
        chk("rst_rec", rec, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_err", err_flags, 0);
        chk("rst_busy", busy, 0);

        // 1: single transaction
        rec_ready = 1'b1;
        go(5); hs(1, 1, 0);
        go(6); hs(0, 0, 0);
        go(7); chk("t1_busy", busy, 1);
        go(9); chk("t1_valid_c9", rec_valid, 0);
        hs(0, 0, 1);
        sb.push_back(mk(REC_TXN, 0, 5, 5, 0));
        go(10); hs(0, 0, 0);
        chk("t1_valid_c10", rec_valid, 1);
        go(12); chk("t1_sb", sb.size(), 0);

        // 2: pipelined
        do_reset();
        rec_ready = 1'b1;
        go(10); hs(1, 1, 0);
        go(11); hs(0, 0, 0);
        go(12); hs(1, 1, 0);
        go(13); hs(0, 0, 0);
        go(14); hs(1, 1, 0);
        go(15); hs(0, 0, 0);
        go(20); hs(0, 0, 1);
        sb.push_back(mk(REC_TXN, 0, 10, 11, 0));
        go(21); sb.push_back(mk(REC_TXN, 1, 12, 10, iiv(2)));
        go(22); sb.push_back(mk(REC_TXN, 2, 14, 9, iiv(2)));
        go(23); hs(0, 0, 0);
        go(26); chk("t2_sb", sb.size(), 0);
        chk("t2_busy", busy, 0);

        // 3: start waits for ready; ready and done together bypass
        do_reset();
        rec_ready = 1'b1;
        go(3); hs(1, 0, 0);
        go(5); chk("t3_busy_wait", busy, 1);
        go(6); hs(1, 1, 1);
        sb.push_back(mk(REC_TXN, 0, 3, 4, 0));
        go(7); hs(0, 0, 0);
        go(9); chk("t3_err", err_flags, 0);
        chk("t3_sb", sb.size(), 0);

        // 4: output backpressure, one record dropped
        do_reset();
        go(2); hs(1, 1, 1);
        for (int i = 0; i < 8; i++) begin
            sb.push_back(mk(REC_TXN, i, 2 + i, 1, (i == 0) ? 0 : iiv(1)));
        end
        first_rec = mk(REC_TXN, 0, 2, 1, 0);
        go(11); hs(0, 0, 0);
        go(13); chk("t4_drop", drop_cnt, 1);
        chk("t4_valid", rec_valid, 1);
        chk("t4_head", rec, first_rec);
        go(16); chk("t4_head_stable", rec, first_rec);
        rec_ready = 1'b1;
        go(28); chk("t4_sb", sb.size(), 0);
        chk("t4_drained", rec_valid, 0);

        // 5: in-flight overflow then orphan done
        do_reset();
        rec_ready = 1'b1;
        go(2); hs(1, 1, 0);
        go(7); hs(0, 0, 0);
        go(8); chk("t5_ovf", err_flags, 2'b01);
        chk("t5_busy", busy, 1);
        go(10); hs(0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            sb.push_back(mk(REC_TXN, i, 2 + i, 9, (i == 0) ? 0 : iiv(1)));
        end
        go(14); hs(0, 0, 0);
        go(15); hs(0, 0, 1);
        go(16); hs(0, 0, 0);
        go(18); chk("t5_orphan", err_flags, 2'b11);
        chk("t5_idle", busy, 0);
        chk("t5_sb", sb.size(), 0);

        // 6: finish with two in flight, summary afterwards
        do_reset();
        rec_ready = 1'b1;
        go(2); hs(1, 1, 0);
        go(3); hs(0, 0, 0);
        go(4); hs(1, 1, 0);
        go(5); hs(0, 0, 0);
        go(6); finish = 1'b1;
        go(7); hs(1, 1, 0);
        go(8); hs(0, 0, 0);
        go(9); hs(0, 0, 1);
        sb.push_back(mk(REC_TXN, 0, 2, 8, 0));
        go(10); sb.push_back(mk(REC_TXN, 1, 4, 7, iiv(2)));
        sb.push_back(mk(REC_SUMMARY, 2, 11, 0, 0));
        go(11); hs(0, 0, 0);
        go(16); chk("t6_sb", sb.size(), 0);
        chk("t6_busy", busy, 1);
        chk("t6_err", err_flags, 0);

        // Mid-run reset discards held records and sticky flags
        do_reset();
        go(2); hs(1, 1, 1);
        go(4); hs(0, 0, 1);
        go(5); hs(0, 0, 0);
        go(6); chk("mr_valid_pre", rec_valid, 1);
        chk("mr_err_pre", err_flags, 2'b10);
        reset = 1'b0;
        @(negedge clock);
        chk("mr_valid", rec_valid, 0);
        chk("mr_rec", rec, 0);
        chk("mr_err", err_flags, 0);
        chk("mr_busy", busy, 0);
        chk("mr_drop", drop_cnt, 0);
        reset = 1'b1;
        go(3);
        chk("end_sb", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
